// File: rtl/cskip_pkg.sv
// rtl/cskip_pkg.sv - shared types and constants for the carry-skip serial adder
package cskip_pkg;

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] RUN_ENC  = 2'd1;
    localparam logic [1:0] DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = IDLE_ENC,
        RUN  = RUN_ENC,
        DONE = DONE_ENC
    } state_t;

    localparam int DEFAULT_SLICE = 4;

    // Ceiling log2, floored at 1 so a single-slice build still gets a 1-bit index
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cskip_slice.sv
// rtl/cskip_slice.sv - combinational carry-skip adder slice
module cskip_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             prop_all
);

    logic [SLICE:0] carry;

    // Ripple chain; when every bit propagates the carry-in bypasses the chain
    always_comb begin
        carry[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        prop_all = &(a ^ b);
        cout     = prop_all ? cin : carry[SLICE];
    end

endmodule

// File: rtl/cskip_serial_add_ctrl.sv
// rtl/cskip_serial_add_ctrl.sv - sequences a wide add through one shared carry-skip slice
module cskip_serial_add_ctrl
    import cskip_pkg::*;
#(
    parameter int  WIDTH      = 16,
    parameter int  SLICE      = DEFAULT_SLICE,
    localparam int NUM_SLICES = WIDTH / SLICE,
    localparam int IDX_W      = clog2(NUM_SLICES),
    localparam int CNT_W      = $clog2(NUM_SLICES + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic [CNT_W-1:0] o_skip_cnt,
    output logic             o_busy
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;
    int               base;
    logic             last;

    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_prop;

    assign base = int'(idx) * SLICE;
    assign last = (idx == IDX_W'(NUM_SLICES - 1));

    cskip_slice #(.SLICE(SLICE)) u_slice (
        .a        (a_reg[base +: SLICE]),
        .b        (b_reg[base +: SLICE]),
        .cin      (carry),
        .sum      (slice_sum),
        .cout     (slice_cout),
        .prop_all (slice_prop)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; no accept while a result is pending
    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        o_busy     = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_next = RUN;
            end
            RUN: begin
                o_busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
                if (i_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and per-slice result assembly; results hold until next accept
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            o_sum      <= '0;
            o_cout     <= 1'b0;
            o_skip_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_reg      <= i_add_term1;
                        b_reg      <= i_add_term2;
                        carry      <= i_cin;
                        idx        <= '0;
                        o_sum      <= '0;
                        o_skip_cnt <= '0;
                    end
                end
                RUN: begin
                    o_sum[base +: SLICE] <= slice_sum;
                    carry                <= slice_cout;
                    if (slice_prop) o_skip_cnt <= o_skip_cnt + CNT_W'(1);
                    if (last) begin
                        o_cout <= slice_cout;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cskip_serial_add_ctrl.sv
// tb/tb_cskip_serial_add_ctrl.sv - directed self-checking bench for the serial carry-skip adder
module tb_cskip_serial_add_ctrl;

    localparam int WIDTH = 16;
    localparam int NS    = 4;

    logic             i_clk;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_add_term1;
    logic [WIDTH-1:0] i_add_term2;
    logic             i_cin;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic [2:0]       o_skip_cnt;
    logic             o_busy;

    int total = 0;
    int bad   = 0;

    cskip_serial_add_ctrl #(.WIDTH(WIDTH), .SLICE(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_add_term1 (i_add_term1),
        .i_add_term2 (i_add_term2),
        .i_cin       (i_cin),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_sum       (o_sum),
        .o_cout      (o_cout),
        .o_skip_cnt  (o_skip_cnt),
        .o_busy      (o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_skip(input logic [15:0] a, input logic [15:0] b);
        int n;
        logic [15:0] p;
        n = 0;
        p = a ^ b;
        for (int s = 0; s < NS; s++) if (p[s*4 +: 4] == 4'hF) n++;
        return n;
    endfunction

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!o_ready && k < 50) begin
            tick();
            k++;
        end
        if (!o_ready) chk({tag, "_ready_timeout"}, 0, 1);
    endtask

    // Accepts one operation, scrambles operands after accept, measures latency, checks result
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] esum, input logic ecout,
                          input int eskip, input bit complete);
        int cyc;
        wait_ready(tag);
        i_add_term1 = a;
        i_add_term2 = b;
        i_cin       = cin;
        i_valid     = 1'b1;
        tick();
        i_valid     = 1'b0;
        i_add_term1 = 16'($urandom);
        i_add_term2 = 16'($urandom);
        i_cin       = 1'($urandom);
        cyc = 0;
        while (!o_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, NS);
        chk({tag, "_sum"}, o_sum, esum);
        chk({tag, "_cout"}, o_cout, ecout);
        chk({tag, "_skip"}, o_skip_cnt, eskip);
        if (complete) begin
            i_ready = 1'b1;
            tick();
            i_ready = 1'b0;
            chk({tag, "_valid_drop"}, o_valid, 0);
            chk({tag, "_ready_back"}, o_ready, 1);
        end
    endtask

    initial begin
        int cyc;
        int gap;
        logic [16:0] full;

        i_rst       = 1'b1;
        i_valid     = 1'b0;
        i_ready     = 1'b0;
        i_add_term1 = '0;
        i_add_term2 = '0;
        i_cin       = 1'b0;
        repeat (3) tick();

        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_sum", o_sum, 0);
        chk("rst_cout", o_cout, 0);
        chk("rst_skip", o_skip_cnt, 0);
        i_rst = 1'b0;
        tick();

        run_op("skipchain", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 3, 1'b1);
        run_op("nocarry",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0, 1'b1);
        run_op("cin_gen",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0, 1'b1);
        run_op("allskip",   16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 4, 1'b1);
        run_op("topgen",    16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0, 1'b1);

        // Backpressure: result held in DONE while new requests are ignored
        run_op("bp", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            i_valid     = 1'(i % 2 == 0);
            i_add_term1 = 16'h1111;
            i_add_term2 = 16'h1111;
            i_cin       = 1'b1;
            tick();
            chk("bp_valid", o_valid, 1);
            chk("bp_sum", o_sum, 16'h5555);
            chk("bp_skip", o_skip_cnt, 0);
            chk("bp_ready", o_ready, 0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("bp_done_valid", o_valid, 0);
        chk("bp_idle_sum_hold", o_sum, 16'h5555);
        chk("bp_idle_busy", o_busy, 0);

        // Back-to-back with request and result handshakes held high
        i_add_term1 = 16'h0F0F;
        i_add_term2 = 16'hF0F0;
        i_cin       = 1'b1;
        i_valid     = 1'b1;
        i_ready     = 1'b1;
        wait_ready("b2b");
        tick();
        i_add_term1 = 16'h9A3C;
        i_add_term2 = 16'h65C4;
        i_cin       = 1'b0;
        cyc = 0;
        gap = -1;
        while (gap < 0 && cyc < 30) begin
            if (o_valid) begin
                chk("b2b_p1_sum", o_sum, 16'h0000);
                chk("b2b_p1_skip", o_skip_cnt, 4);
            end
            if (o_ready) gap = cyc + 1;
            tick();
            cyc++;
        end
        chk("b2b_gap", gap, NS + 2);
        i_valid = 1'b0;
        i_add_term1 = 16'h0000;
        i_add_term2 = 16'h0000;
        cyc = 0;
        while (!o_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        full = 17'(16'h9A3C) + 17'(16'h65C4);
        chk("b2b_p2_latency", cyc, NS);
        chk("b2b_p2_sum", o_sum, full[15:0]);
        chk("b2b_p2_cout", o_cout, full[16]);
        chk("b2b_p2_skip", o_skip_cnt, model_skip(16'h9A3C, 16'h65C4));
        tick();
        i_ready = 1'b0;
        chk("b2b_end_valid", o_valid, 0);

        // Reset two cycles into RUN with a nonzero partial result
        wait_ready("rstrun");
        i_add_term1 = 16'h1234;
        i_add_term2 = 16'h4321;
        i_cin       = 1'b0;
        i_valid     = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
        #1;
        chk("midrun_valid", o_valid, 0);
        chk("midrun_sum", o_sum, 0);
        chk("midrun_skip", o_skip_cnt, 0);
        chk("midrun_ready", o_ready, 1);
        chk("midrun_busy", o_busy, 0);
        tick();
        i_rst = 1'b0;
        tick();
        run_op("postrst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
